// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, op codes, sequencer states, latencies.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int MUL_LAT    = 34;
    localparam int DIV_LAT    = 37;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PREP_A,
        PREP_B,
        ITER,
        FIX_Q,
        FIX_R,
        DONE
    } state_t;

    // Majority of three bits; gives the carry out of bit 31 from its inputs.
    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mul_div_sequencer.sv
// Signed MUL (radix-2 Booth) / DIV (restoring on magnitudes) over the shared ALU adder.
// Latency: MUL done 34 cycles after start, DIV 37, DIV by zero 1.
// Backpressure: start ignored while busy; accepted in IDLE or DONE.
module mul_div_sequencer
    import alu_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] DBZ_QUOTIENT = 32'hFFFFFFFF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] resultHI,
    output logic [WIDTH-1:0] resultLO,
    output logic [WIDTH-1:0] addA,
    output logic [WIDTH-1:0] addB,
    input  logic [WIDTH-1:0] addSum,
    input  logic             addCarry
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] nreg;     // -M for MUL, -|D| for DIV
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q1;
    logic [5:0]       cnt;

    logic             cout;
    logic             booth_add;
    logic             ae32;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] msum;
    logic             ms32;
    logic [WIDTH-1:0] mhi_n;
    logic [WIDTH-1:0] mlo_n;
    logic [WIDTH-1:0] dhi_n;
    logic [WIDTH-1:0] dlo_n;
    logic             last_iter;

    assign cout      = maj(addA[WIDTH-1], addB[WIDTH-1], addCarry);
    assign last_iter = (cnt == 6'(ITER_COUNT - 1));

    // Adder operand selection per state plus next-value datapath for MUL and DIV.
    always_comb begin
        addA      = '0;
        addB      = '0;
        booth_add = 1'b0;
        ae32      = 1'b0;
        r_sh      = {hi[WIDTH-2:0], lo[WIDTH-1]};
        case (state)
            PREP_A: begin
                if (opa[WIDTH-1]) begin
                    addA = ~opa;
                    addB = ONE;
                end
            end
            PREP_B: begin
                addA = (op_q == OP_MUL) ? ~opa : ~opb;
                addB = ONE;
            end
            ITER: begin
                if (op_q == OP_MUL) begin
                    if ({lo[0], q1} == 2'b01) begin
                        addA      = hi;
                        addB      = opa;
                        booth_add = 1'b1;
                        ae32      = opa[WIDTH-1];
                    end else if ({lo[0], q1} == 2'b10) begin
                        addA      = hi;
                        addB      = nreg;
                        booth_add = 1'b1;
                        // -M is negative exactly when M is strictly positive
                        ae32      = ~opa[WIDTH-1] & (opa != '0);
                    end
                end else begin
                    addA = r_sh;
                    addB = nreg;
                end
            end
            FIX_Q: begin
                if (opa[WIDTH-1] ^ opb[WIDTH-1]) begin
                    addA = ~lo;
                    addB = ONE;
                end
            end
            FIX_R: begin
                if (opa[WIDTH-1]) begin
                    addA = ~hi;
                    addB = ONE;
                end
            end
            default: ;
        endcase
        // Bit 32 of the sign-extended 33-bit sum hi + addend
        msum  = booth_add ? addSum : hi;
        ms32  = booth_add ? (hi[WIDTH-1] ^ ae32 ^ cout) : hi[WIDTH-1];
        mhi_n = {ms32, msum[WIDTH-1:1]};
        mlo_n = {msum[0], lo[WIDTH-1:1]};
        // Carry out of R + (-|D|) means R >= |D|
        dhi_n = cout ? addSum : r_sh;
        dlo_n = {lo[WIDTH-2:0], cout};
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            op_q      <= OP_MUL;
            opa       <= '0;
            opb       <= '0;
            nreg      <= '0;
            hi        <= '0;
            lo        <= '0;
            q1        <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            resultHI  <= '0;
            resultLO  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        op_q      <= op;
                        opa       <= operandA;
                        opb       <= operandB;
                        divByZero <= 1'b0;
                        if (op == OP_MUL) begin
                            state <= PREP_B;
                            busy  <= 1'b1;
                        end else if (operandB == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            divByZero <= 1'b1;
                            resultHI  <= operandA;
                            resultLO  <= DBZ_QUOTIENT;
                        end else begin
                            state <= PREP_A;
                            busy  <= 1'b1;
                        end
                    end
                end
                PREP_A: begin
                    lo    <= opa[WIDTH-1] ? addSum : opa;
                    hi    <= '0;
                    state <= PREP_B;
                end
                PREP_B: begin
                    if (op_q == OP_MUL) begin
                        nreg <= addSum;
                        hi   <= '0;
                        lo   <= opb;
                    end else begin
                        nreg <= opb[WIDTH-1] ? opb : addSum;
                    end
                    q1    <= 1'b0;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    cnt <= cnt + 6'd1;
                    if (op_q == OP_MUL) begin
                        hi <= mhi_n;
                        lo <= mlo_n;
                        q1 <= lo[0];
                        if (last_iter) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            resultHI <= mhi_n;
                            resultLO <= mlo_n;
                        end
                    end else begin
                        hi <= dhi_n;
                        lo <= dlo_n;
                        if (last_iter) begin
                            state <= FIX_Q;
                        end
                    end
                end
                FIX_Q: begin
                    if (opa[WIDTH-1] ^ opb[WIDTH-1]) begin
                        lo <= addSum;
                    end
                    state <= FIX_R;
                end
                FIX_R: begin
                    resultHI <= opa[WIDTH-1] ? addSum : hi;
                    resultLO <= lo;
                    state    <= DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with a behavioural adder and result scoreboard.
// Latency: expected done cycle tracked per operation.
// Backpressure: start pulses while busy must be ignored.
module tb_mul_div_sequencer;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] resultHI;
    logic [31:0] resultLO;
    logic [31:0] addA;
    logic [31:0] addB;
    logic [31:0] addSum;
    logic        addCarry;
    logic [31:0] low_sum;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    // Behavioural carry-lookahead stand-in: sum and carry into bit 31.
    assign addSum   = addA + addB;
    assign low_sum  = {1'b0, addA[30:0]} + {1'b0, addB[30:0]};
    assign addCarry = low_sum[31];

    mul_div_sequencer dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .resultHI  (resultHI),
        .resultLO  (resultLO),
        .addA      (addA),
        .addB      (addB),
        .addSum    (addSum),
        .addCarry  (addCarry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] p;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        e.dbz = 1'b0;
        if (o == 1'b0) begin
            p     = sa * sbv;
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = 34;
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFFFFFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q     = sa / sbv;
            r     = sa % sbv;
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.lat = 37;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Drive start for one edge; returns one step after that edge (cycle 1).
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        if (push) sb.push_back(model(o, a, b));
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        bit   busy_ok;
        busy_ok = 1'b1;
        while (!done && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            tick();
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"},    {31'd0, done},      32'd1);
            check({tag, "_latency"}, cyc,                e.lat);
            check({tag, "_busy"},    {31'd0, busy_ok},   32'd1);
            check({tag, "_busy_dn"}, {31'd0, busy},      32'd0);
            check({tag, "_hi"},      resultHI,           e.hi);
            check({tag, "_lo"},      resultLO,           e.lo);
            check({tag, "_dbz"},     {31'd0, divByZero}, {31'd0, e.dbz});
        end
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        operandA = '0;
        operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy},      32'd0);
        check("rst_done", {31'd0, done},      32'd0);
        check("rst_dbz",  {31'd0, divByZero}, 32'd0);
        check("rst_hi",   resultHI,           32'd0);
        check("rst_lo",   resultLO,           32'd0);
        check("rst_addA", addA,               32'd0);
        check("rst_addB", addB,               32'd0);
        resetn = 1'b1;
        tick();

        // Directed MUL cases, including the -M sign corner
        issue(1'b0, 32'd7, 32'hFFFFFFFD, 1'b1);
        wait_done("mul_7x-3");
        check("mul_7x-3_hi_const", resultHI, 32'hFFFFFFFF);
        check("mul_7x-3_lo_const", resultLO, 32'hFFFFFFEB);
        tick();
        issue(1'b0, 32'h80000000, 32'h80000000, 1'b1);
        wait_done("mul_min_sq");
        tick();
        issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        wait_done("mul_max_sq");
        tick();

        // Directed DIV cases, back-to-back issue in the DONE cycle
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done("div_-7/2");
        issue(1'b1, 32'd100, 32'hFFFFFFF9, 1'b1);
        wait_done("div_100/-7");
        tick();

        // Divide by zero then a new start clears the flag
        issue(1'b1, 32'd100, 32'd0, 1'b1);
        wait_done("div_by_zero");
        tick();
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        check("dbz_cleared", {31'd0, divByZero}, 32'd0);
        wait_done("div_min/-1");
        tick();

        // start during ITER must be ignored
        issue(1'b0, 32'd12345, 32'hFFFF0001, 1'b1);
        repeat (10) tick();
        op       = 1'b1;
        operandA = 32'd5;
        operandB = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done("mul_ignore_start");
        tick();

        // A few random operations
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 2) rb = {28'd0, rb[3:0]} + 32'd1;
            issue(i[0], ra, rb, 1'b1);
            wait_done($sformatf("rand%0d", i));
            tick();
        end

        // Reset mid-operation aborts without a done pulse
        issue(1'b0, 32'd9, 32'd9, 1'b0);
        repeat (11) tick();
        resetn = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi",   resultHI,      32'd0);
        check("abort_lo",   resultLO,      32'd0);
        check("abort_addA", addA,          32'd0);
        check("abort_addB", addB,          32'd0);
        resetn = 1'b1;
        repeat (3) tick();
        check("abort_no_done", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
